// File: rtl/route_compute_unit.sv
// Registered dimension-ordered route-compute stage for one mesh router input port.
// Header flits pick the output port (XY or YX order); body/tail flits reuse the locked port.
module route_compute_unit #(
    parameter int X_NODE_NUM       = 4,
    parameter int Y_NODE_NUM       = 4,
    parameter int X_NODE_NUM_WIDTH = 2,
    parameter int Y_NODE_NUM_WIDTH = 2,
    parameter int X_S_ADDR         = 1,
    parameter int Y_S_ADDR         = 1,
    parameter int FLIT_W           = 16,
    parameter bit ROUTE_YX         = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] flit_in,
    input  logic              flit_valid,
    output logic              flit_ready,
    output logic [FLIT_W-1:0] flit_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        port_num,
    output logic [4:0]        port_req,
    output logic              route_err
);

    localparam int XW = X_NODE_NUM_WIDTH;
    localparam int YW = Y_NODE_NUM_WIDTH;
    localparam logic [XW-1:0] XC = X_S_ADDR[XW-1:0];
    localparam logic [YW-1:0] YC = Y_S_ADDR[YW-1:0];

    localparam logic [2:0] PORT_L = 3'd1;
    localparam logic [2:0] PORT_E = 3'd2;
    localparam logic [2:0] PORT_N = 3'd3;
    localparam logic [2:0] PORT_W = 3'd4;
    localparam logic [2:0] PORT_S = 3'd5;

    typedef enum logic {
        IDLE   = 1'b0,
        PACKET = 1'b1
    } state_t;

    state_t     state;
    logic [2:0] locked_port;

    logic [1:0]    flit_type;
    logic          is_hdr;
    logic          is_tail;
    logic [XW-1:0] dest_x;
    logic [YW-1:0] dest_y;
    logic [XW:0]   xdiff;
    logic [YW:0]   ydiff;
    logic          x_neg;
    logic          x_zero;
    logic          y_neg;
    logic          y_zero;
    logic          addr_bad;
    logic [2:0]    route_port;
    logic          accept;

    // Handshake: a flit moves in on flit_valid && flit_ready and out on out_valid && out_ready;
    // the output register may be refilled in the same cycle it drains.
    assign flit_ready = !out_valid || out_ready;
    assign accept     = flit_valid && flit_ready;

    assign flit_type = flit_in[FLIT_W-1 -: 2];
    assign is_hdr    = flit_type[1];
    assign is_tail   = flit_type[0];
    assign dest_y    = flit_in[YW-1:0];
    assign dest_x    = flit_in[YW +: XW];

    assign xdiff  = {1'b0, dest_x} - {1'b0, XC};
    assign ydiff  = {1'b0, dest_y} - {1'b0, YC};
    assign x_neg  = xdiff[XW];
    assign y_neg  = ydiff[YW];
    assign x_zero = (xdiff == '0);
    assign y_zero = (ydiff == '0);

    assign addr_bad = (int'(dest_x) >= X_NODE_NUM) || (int'(dest_y) >= Y_NODE_NUM);

    always_comb begin
        route_port = PORT_L;
        if (!ROUTE_YX) begin
            if (!x_zero)      route_port = x_neg ? PORT_W : PORT_E;
            else if (!y_zero) route_port = y_neg ? PORT_N : PORT_S;
        end else begin
            if (!y_zero)      route_port = y_neg ? PORT_N : PORT_S;
            else if (!x_zero) route_port = x_neg ? PORT_W : PORT_E;
        end
    end

    function automatic logic [4:0] port_onehot(input logic [2:0] p);
        logic [4:0] oh;
        oh = 5'b00000;
        case (p)
            PORT_L:  oh = 5'b00001;
            PORT_E:  oh = 5'b00010;
            PORT_W:  oh = 5'b00100;
            PORT_S:  oh = 5'b01000;
            PORT_N:  oh = 5'b10000;
            default: oh = 5'b00000;
        endcase
        return oh;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            locked_port <= 3'd0;
            out_valid   <= 1'b0;
            flit_out    <= '0;
            port_num    <= 3'd0;
            port_req    <= 5'd0;
            route_err   <= 1'b0;
        end else begin
            route_err <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                port_req  <= 5'd0;
            end
            if (accept) begin
                if (state == IDLE) begin
                    // Only a well-addressed header may open a route from IDLE.
                    if (!is_hdr || addr_bad) begin
                        route_err <= 1'b1;
                    end else begin
                        out_valid <= 1'b1;
                        flit_out  <= flit_in;
                        port_num  <= route_port;
                        port_req  <= port_onehot(route_port);
                        if (!is_tail) begin
                            state       <= PACKET;
                            locked_port <= route_port;
                        end
                    end
                end else begin
                    if (is_hdr) begin
                        route_err <= 1'b1;
                    end else begin
                        out_valid <= 1'b1;
                        flit_out  <= flit_in;
                        port_num  <= locked_port;
                        port_req  <= port_onehot(locked_port);
                        if (is_tail) state <= IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_route_compute_unit.sv
// Bench for route_compute_unit: three instances (XY, YX, 3-column mesh) share stimulus and are
// compared every cycle against a packet-level reference model plus directed literal checks.
module tb_route_compute_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flit_valid;
    logic        out_ready;
    logic [15:0] flit_in;

    logic        fr  [3];
    logic        ov  [3];
    logic        err [3];
    logic [15:0] fo  [3];
    logic [2:0]  pn  [3];
    logic [4:0]  pq  [3];

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] T_HDR  = 2'b10;
    localparam logic [1:0] T_BODY = 2'b00;
    localparam logic [1:0] T_TAIL = 2'b01;
    localparam logic [1:0] T_HT   = 2'b11;

    always #5 clk = ~clk;

    route_compute_unit #(.X_NODE_NUM(4), .Y_NODE_NUM(4), .X_NODE_NUM_WIDTH(2), .Y_NODE_NUM_WIDTH(2),
        .X_S_ADDR(1), .Y_S_ADDR(1), .FLIT_W(16), .ROUTE_YX(1'b0)) dut_xy (
        .clk(clk), .rst(rst), .flit_in(flit_in), .flit_valid(flit_valid), .flit_ready(fr[0]),
        .flit_out(fo[0]), .out_valid(ov[0]), .out_ready(out_ready), .port_num(pn[0]),
        .port_req(pq[0]), .route_err(err[0]));

    route_compute_unit #(.X_NODE_NUM(4), .Y_NODE_NUM(4), .X_NODE_NUM_WIDTH(2), .Y_NODE_NUM_WIDTH(2),
        .X_S_ADDR(1), .Y_S_ADDR(1), .FLIT_W(16), .ROUTE_YX(1'b1)) dut_yx (
        .clk(clk), .rst(rst), .flit_in(flit_in), .flit_valid(flit_valid), .flit_ready(fr[1]),
        .flit_out(fo[1]), .out_valid(ov[1]), .out_ready(out_ready), .port_num(pn[1]),
        .port_req(pq[1]), .route_err(err[1]));

    route_compute_unit #(.X_NODE_NUM(3), .Y_NODE_NUM(4), .X_NODE_NUM_WIDTH(2), .Y_NODE_NUM_WIDTH(2),
        .X_S_ADDR(1), .Y_S_ADDR(1), .FLIT_W(16), .ROUTE_YX(1'b0)) dut_x3 (
        .clk(clk), .rst(rst), .flit_in(flit_in), .flit_valid(flit_valid), .flit_ready(fr[2]),
        .flit_out(fo[2]), .out_valid(ov[2]), .out_ready(out_ready), .port_num(pn[2]),
        .port_req(pq[2]), .route_err(err[2]));

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        ov;
        logic [15:0] fo;
        logic [2:0]  pn;
        logic        err;
        logic        pkt;
        logic [2:0]  lock;
    } mstate_t;

    mstate_t     m [3];
    bit          started = 1'b0;
    logic [15:0] exp_q [$];

    function automatic logic [2:0] route(input int xd, input int yd, input bit yx);
        int dx;
        int dy;
        dx = xd - 1;
        dy = yd - 1;
        if (!yx) begin
            if (dx > 0) return 3'd2;
            if (dx < 0) return 3'd4;
            if (dy > 0) return 3'd5;
            if (dy < 0) return 3'd3;
        end else begin
            if (dy > 0) return 3'd5;
            if (dy < 0) return 3'd3;
            if (dx > 0) return 3'd2;
            if (dx < 0) return 3'd4;
        end
        return 3'd1;
    endfunction

    function automatic logic [4:0] req_of(input logic [2:0] p);
        case (p)
            3'd1:    return 5'b00001;
            3'd2:    return 5'b00010;
            3'd3:    return 5'b10000;
            3'd4:    return 5'b00100;
            3'd5:    return 5'b01000;
            default: return 5'b00000;
        endcase
    endfunction

    task automatic model_step(input int i);
        int         xn;
        bit         yx;
        bit         acc;
        logic [1:0] ty;
        int         xd;
        int         yd;
        logic [2:0] p;
        xn = (i == 2) ? 3 : 4;
        yx = (i == 1);
        if (rst) begin
            m[i] = '0;
            if (i == 0) begin
                exp_q.delete();
                started = 1'b1;
            end
            return;
        end
        acc = flit_valid && (!m[i].ov || out_ready);
        m[i].err = 1'b0;
        if (m[i].ov && out_ready) m[i].ov = 1'b0;
        if (!acc) return;
        ty = flit_in[15:14];
        xd = int'(flit_in[3:2]);
        yd = int'(flit_in[1:0]);
        if (!m[i].pkt) begin
            if (!ty[1] || xd >= xn || yd >= 4) begin
                m[i].err = 1'b1;
                return;
            end
            p = route(xd, yd, yx);
            if (ty == T_HDR) begin
                m[i].pkt  = 1'b1;
                m[i].lock = p;
            end
        end else begin
            if (ty[1]) begin
                m[i].err = 1'b1;
                return;
            end
            p = m[i].lock;
            if (ty == T_TAIL) m[i].pkt = 1'b0;
        end
        m[i].ov = 1'b1;
        m[i].fo = flit_in;
        m[i].pn = p;
        if (i == 0) exp_q.push_back(flit_in);
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) model_step(i);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("d%0d_out_valid", i), 32'(ov[i]), 32'(m[i].ov));
                chk($sformatf("d%0d_route_err", i), 32'(err[i]), 32'(m[i].err));
                chk($sformatf("d%0d_flit_ready", i), 32'(fr[i]), 32'(!m[i].ov || out_ready));
                chk($sformatf("d%0d_port_req", i), 32'(pq[i]), 32'(m[i].ov ? req_of(m[i].pn) : 5'd0));
                if (m[i].ov) begin
                    chk($sformatf("d%0d_flit_out", i), 32'(fo[i]), 32'(m[i].fo));
                    chk($sformatf("d%0d_port_num", i), 32'(pn[i]), 32'(m[i].pn));
                end
            end
            if (ov[0] && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow actual=%0h required=none at %0t", fo[0], $time);
                end else begin
                    chk("sb_order", 32'(fo[0]), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic [15:0] f, input logic ordy, input logic r,
                         output bit acc);
        flit_valid = v;
        flit_in    = f;
        out_ready  = ordy;
        rst        = r;
        #1;
        acc = v && fr[0] && !r;
        @(posedge clk);
        #1;
    endtask

    task automatic send_hold(input logic [15:0] f, input logic ordy);
        bit a;
        int n;
        n = 0;
        do begin
            drive(1'b1, f, ordy, 1'b0, a);
            n++;
        end while (!a && n < 50);
        if (!a) begin
            checks++;
            errors++;
            $display("FAIL hold_timeout actual=not_accepted required=accepted at %0t", $time);
        end
    endtask

    function automatic logic [15:0] mk(input logic [1:0] ty, input int x, input int y);
        logic [9:0] pl;
        pl = 10'($urandom);
        return {ty, pl, 2'(x), 2'(y)};
    endfunction

    // ---------------- directed + random stimulus ----------------
    initial begin
        bit          a;
        bit          r;
        bit          v;
        bit          gp;
        bit          pending;
        logic [1:0]  ty;
        logic [15:0] f;
        logic [15:0] hdr_f;
        logic [15:0] tail_f;
        int          ht_x [3];
        int          ht_y [3];
        int          ht_pn[3];
        int          ht_pq[3];

        flit_valid = 1'b0;
        flit_in    = '0;
        out_ready  = 1'b1;
        rst        = 1'b1;
        drive(1'b0, 16'h0, 1'b1, 1'b1, a);
        drive(1'b0, 16'h0, 1'b1, 1'b1, a);

        chk("rst_out_valid", 32'(ov[0]), 0);
        chk("rst_flit_out", 32'(fo[0]), 0);
        chk("rst_port_num", 32'(pn[0]), 0);
        chk("rst_port_req", 32'(pq[0]), 0);
        chk("rst_route_err", 32'(err[0]), 0);
        drive(1'b0, 16'h0, 1'b1, 1'b0, a);
        chk("rst_flit_ready", 32'(fr[0]), 1);

        // wormhole packet east
        f = mk(T_HDR, 3, 1);
        drive(1'b1, f, 1'b1, 1'b0, a);
        chk("pk_hdr_flit", 32'(fo[0]), 32'(f));
        chk("pk_hdr_pn", 32'(pn[0]), 2);
        chk("pk_hdr_pq", 32'(pq[0]), 32'(5'b00010));
        f = mk(T_BODY, 0, 0);
        drive(1'b1, f, 1'b1, 1'b0, a);
        chk("pk_body_pn", 32'(pn[0]), 2);
        chk("pk_body_flit", 32'(fo[0]), 32'(f));
        f = mk(T_TAIL, 2, 3);
        drive(1'b1, f, 1'b1, 1'b0, a);
        chk("pk_tail_pn", 32'(pn[0]), 2);
        chk("pk_tail_pq", 32'(pq[0]), 32'(5'b00010));

        // BODY in IDLE is an error (also proves the TAIL returned to IDLE)
        drive(1'b1, mk(T_BODY, 1, 1), 1'b1, 1'b0, a);
        chk("idle_body_err", 32'(err[0]), 1);
        chk("idle_body_ov", 32'(ov[0]), 0);
        drive(1'b0, 16'h0, 1'b1, 1'b0, a);
        chk("err_pulse_one", 32'(err[0]), 0);

        // HDR inside a packet keeps the locked route
        drive(1'b1, mk(T_HDR, 3, 1), 1'b1, 1'b0, a);
        drive(1'b1, mk(T_HDR, 1, 3), 1'b1, 1'b0, a);
        chk("pkt_hdr_err", 32'(err[0]), 1);
        chk("pkt_hdr_ov", 32'(ov[0]), 0);
        drive(1'b1, mk(T_TAIL, 0, 0), 1'b1, 1'b0, a);
        chk("pkt_lock_pn", 32'(pn[0]), 2);
        chk("pkt_lock_ov", 32'(ov[0]), 1);

        // single-flit packets
        ht_x = '{1, 1, 0};
        ht_y = '{3, 1, 0};
        ht_pn = '{5, 1, 4};
        ht_pq = '{8, 1, 4};
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, mk(T_HT, ht_x[k], ht_y[k]), 1'b1, 1'b0, a);
            chk($sformatf("ht%0d_pn", k), 32'(pn[0]), 32'(ht_pn[k]));
            chk($sformatf("ht%0d_pq", k), 32'(pq[0]), 32'(ht_pq[k]));
        end

        // XY vs YX order
        drive(1'b1, mk(T_HT, 3, 3), 1'b1, 1'b0, a);
        chk("xy_33_pn", 32'(pn[0]), 2);
        chk("yx_33_pn", 32'(pn[1]), 5);
        drive(1'b1, mk(T_HT, 1, 0), 1'b1, 1'b0, a);
        chk("yx_10_pn", 32'(pn[1]), 3);
        chk("yx_10_pq", 32'(pq[1]), 32'(5'b10000));

        // out-of-range column on the 3-column mesh
        drive(1'b1, mk(T_HT, 3, 1), 1'b1, 1'b0, a);
        chk("x3_err", 32'(err[2]), 1);
        chk("x3_ov", 32'(ov[2]), 0);
        chk("x4_ok_ov", 32'(ov[0]), 1);

        // backpressure with a 4-flit packet
        hdr_f = mk(T_HDR, 1, 2);
        drive(1'b1, hdr_f, 1'b1, 1'b0, a);
        f = mk(T_BODY, 0, 1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, f, 1'b0, 1'b0, a);
            chk($sformatf("bp%0d_no_accept", k), 32'(a), 0);
            chk($sformatf("bp%0d_hold_flit", k), 32'(fo[0]), 32'(hdr_f));
            chk($sformatf("bp%0d_hold_pn", k), 32'(pn[0]), 5);
            chk($sformatf("bp%0d_ready", k), 32'(fr[0]), 0);
        end
        send_hold(f, 1'b1);
        send_hold(mk(T_BODY, 2, 2), 1'b1);
        tail_f = mk(T_TAIL, 3, 0);
        send_hold(tail_f, 1'b1);
        chk("bp_tail_flit", 32'(fo[0]), 32'(tail_f));
        chk("bp_tail_pn", 32'(pn[0]), 5);

        // reset in the middle of a packet
        drive(1'b1, mk(T_HDR, 3, 1), 1'b1, 1'b0, a);
        drive(1'b0, 16'h0, 1'b1, 1'b1, a);
        chk("mid_rst_ov", 32'(ov[0]), 0);
        chk("mid_rst_flit", 32'(fo[0]), 0);
        chk("mid_rst_pn", 32'(pn[0]), 0);
        chk("mid_rst_pq", 32'(pq[0]), 0);
        drive(1'b1, mk(T_TAIL, 0, 0), 1'b1, 1'b0, a);
        chk("mid_rst_tail_err", 32'(err[0]), 1);
        drive(1'b1, mk(T_HT, 3, 1), 1'b1, 1'b0, a);
        chk("mid_rst_hdr_pn", 32'(pn[0]), 2);
        chk("mid_rst_hdr_err", 32'(err[0]), 0);

        // randomized traffic
        gp = 1'b0;
        pending = 1'b0;
        v = 1'b0;
        ty = T_HDR;
        f = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!pending) begin
                v = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 9) == 0) ty = 2'($urandom);
                else if (gp) ty = ($urandom_range(0, 2) == 0) ? T_TAIL : T_BODY;
                else ty = ($urandom_range(0, 2) == 0) ? T_HT : T_HDR;
                f = mk(ty, $urandom_range(0, 3), $urandom_range(0, 3));
            end
            r = ($urandom_range(0, 499) == 0);
            drive(v, f, ($urandom_range(0, 3) != 0), r, a);
            if (r) begin
                gp = 1'b0;
                pending = 1'b0;
            end else if (v && !a) begin
                pending = 1'b1;
            end else begin
                pending = 1'b0;
                if (a && ty == T_HDR && !gp) gp = 1'b1;
                else if (a && ty == T_TAIL && gp) gp = 1'b0;
            end
        end

        for (int k = 0; k < 3; k++) drive(1'b0, 16'h0, 1'b1, 1'b0, a);
        chk("sb_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
